// File: rtl/select_out_arb_if.sv
// Handshake bundle for select_out_arb: channel select, input-channel pop side and output FIFO side.
interface select_out_arb_if #(
  parameter int unsigned funnelWidth = 8,
  parameter int unsigned width       = 16
);
  localparam int unsigned CW = $clog2(funnelWidth);

  logic                         select__ENA;
  logic [31:0]                  select_v;
  logic                         select__RDY;
  logic [funnelWidth-1:0]       in__deq__ENA;
  logic [funnelWidth-1:0]       in__deq__RDY;
  logic [funnelWidth*width-1:0] in__first;
  logic [funnelWidth-1:0]       in__first__RDY;
  logic                         out__deq__ENA;
  logic                         out__deq__RDY;
  logic [width-1:0]             out__first;
  logic                         out__first__RDY;
  logic [CW-1:0]                out__chan;

  modport slave (
    input  select__ENA, select_v, in__deq__RDY, in__first, in__first__RDY, out__deq__ENA,
    output select__RDY, in__deq__ENA, out__deq__RDY, out__first, out__first__RDY, out__chan
  );

  modport master (
    output select__ENA, select_v, in__deq__RDY, in__first, in__first__RDY, out__deq__ENA,
    input  select__RDY, in__deq__ENA, out__deq__RDY, out__first, out__first__RDY, out__chan
  );
endinterface

// File: rtl/select_out_arb.sv
// Funnels funnelWidth input channels into one registered, channel-tagged output FIFO,
// choosing the source by sticky select (mode 0) or round-robin from the select pointer (mode 1).
module select_out_arb #(
  parameter int unsigned funnelWidth = 8,
  parameter int unsigned width       = 16,
  parameter int unsigned depth       = 2,
  parameter int unsigned mode        = 0
) (
  input logic             CLK,
  input logic             RST,
  select_out_arb_if.slave bus
);
  localparam int unsigned CW = $clog2(funnelWidth);
  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] DepthC = (AW+1)'(depth);

  logic [funnelWidth-1:0] elig;
  logic [funnelWidth-1:0] deq_ena;
  logic [CW-1:0]          cur_q, cur_d;
  logic [CW-1:0]          grant, idx;
  logic                   grant_vld;
  logic                   pull, pop, not_empty;
  logic [width-1:0]       data_q [depth];
  logic [CW-1:0]          chan_q [depth];
  logic [AW-1:0]          rd_ptr_q, wr_ptr_q;
  logic [AW:0]            count_q, count_d;

  assign elig = bus.in__deq__RDY & bus.in__first__RDY;

  // Mode 1 scans cur, cur+1, ... so the pointer itself has top priority.
  always_comb begin
    grant     = cur_q;
    grant_vld = 1'b0;
    idx       = '0;
    if (mode == 0) begin
      grant_vld = elig[cur_q];
    end else begin
      for (int unsigned i = 0; i < funnelWidth; i++) begin
        idx = CW'((32'(cur_q) + i) % funnelWidth);
        if (!grant_vld && elig[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Pull is decided before any same-cycle pop: no consumer-to-producer combinational path.
  assign pull      = !RST && grant_vld && (count_q < DepthC);
  assign not_empty = (count_q != '0);
  assign pop       = bus.out__deq__ENA && not_empty;

  always_comb begin
    deq_ena = '0;
    if (pull) deq_ena[grant] = 1'b1;
  end

  always_comb begin
    cur_d = cur_q;
    if (bus.select__ENA && (bus.select_v < 32'(funnelWidth))) begin
      cur_d = bus.select_v[CW-1:0];
    end else if ((mode == 1) && pull) begin
      cur_d = (32'(grant) == funnelWidth - 1) ? '0 : grant + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({pull, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < depth; i++) begin
        data_q[i] <= '0;
        chan_q[i] <= '0;
      end
    end else begin
      cur_q   <= cur_d;
      count_q <= count_d;
      if (pull) begin
        data_q[wr_ptr_q] <= bus.in__first[32'(grant)*width +: width];
        chan_q[wr_ptr_q] <= grant;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign bus.select__RDY     = !RST;
  assign bus.in__deq__ENA    = deq_ena;
  assign bus.out__deq__RDY   = not_empty;
  assign bus.out__first__RDY = not_empty;
  assign bus.out__first      = not_empty ? data_q[rd_ptr_q] : '0;
  assign bus.out__chan       = not_empty ? chan_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_select_out_arb.sv
// Directed bench: one mode-0 and one mode-1 instance share stimulus; each task checks one scenario.
module tb_select_out_arb;
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         sel_ena;
  logic [31:0]  sel_v;
  logic [7:0]   deq_rdy, first_rdy;
  logic [127:0] first_data;
  logic         out_deq;
  int           checks = 0;
  int           passed = 0;

  always #5 CLK = ~CLK;

  select_out_arb_if #(.funnelWidth(8), .width(16)) b0 ();
  select_out_arb_if #(.funnelWidth(8), .width(16)) b1 ();

  assign b0.select__ENA    = sel_ena;
  assign b0.select_v       = sel_v;
  assign b0.in__deq__RDY   = deq_rdy;
  assign b0.in__first__RDY = first_rdy;
  assign b0.in__first      = first_data;
  assign b0.out__deq__ENA  = out_deq;
  assign b1.select__ENA    = sel_ena;
  assign b1.select_v       = sel_v;
  assign b1.in__deq__RDY   = deq_rdy;
  assign b1.in__first__RDY = first_rdy;
  assign b1.in__first      = first_data;
  assign b1.out__deq__ENA  = out_deq;

  select_out_arb #(.funnelWidth(8), .width(16), .depth(2), .mode(0)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (b0)
  );

  select_out_arb #(.funnelWidth(8), .width(16), .depth(2), .mode(1)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (b1)
  );

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic set_elig(input logic [7:0] m);
    deq_rdy   = m;
    first_rdy = m;
  endtask

  task automatic set_data(input int ch, input logic [15:0] v);
    first_data[ch*16 +: 16] = v;
  endtask

  task automatic do_reset;
    RST        = 1'b1;
    sel_ena    = 1'b0;
    sel_v      = '0;
    first_data = '0;
    out_deq    = 1'b0;
    set_elig(8'h00);
    @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    set_elig(8'hff);
    out_deq = 1'b1;
    #1;
    checks++;
    if (b1.in__deq__ENA !== 8'h00) $display("FAIL rst_deq_ena: got %h want 00", b1.in__deq__ENA);
    else passed++;
    checks++;
    if (b0.select__RDY !== 1'b0) $display("FAIL rst_select_rdy: got %b want 0", b0.select__RDY);
    else passed++;
    checks++;
    if ({b0.out__deq__RDY, b0.out__first__RDY} !== 2'b00)
      $display("FAIL rst_out_rdy: got %b want 00", {b0.out__deq__RDY, b0.out__first__RDY});
    else passed++;
    checks++;
    if ({b1.out__first, b1.out__chan} !== 19'h0)
      $display("FAIL rst_out_data: got %h/%h want 0/0", b1.out__first, b1.out__chan);
    else passed++;
    do_reset();
    #1;
    checks++;
    if (b0.select__RDY !== 1'b1) $display("FAIL select_rdy: got %b want 1", b0.select__RDY);
    else passed++;
  endtask

  task automatic test_sticky_select;
    do_reset();
    sel_ena = 1'b1;
    sel_v   = 32'd3;
    #1;
    checks++;
    if (b0.in__deq__ENA !== 8'h00) $display("FAIL st_pre: got %h want 00", b0.in__deq__ENA);
    else passed++;
    tick();
    sel_ena = 1'b0;
    set_elig(8'h08);
    set_data(3, 16'hA5A5);
    #1;
    checks++;
    if (b0.in__deq__ENA !== 8'h08) $display("FAIL st_ena: got %h want 08", b0.in__deq__ENA);
    else passed++;
    tick();
    set_elig(8'h00);
    #1;
    checks++;
    if (b0.out__first !== 16'hA5A5) $display("FAIL st_data: got %h want a5a5", b0.out__first);
    else passed++;
    checks++;
    if (b0.out__chan !== 3'd3) $display("FAIL st_chan: got %0d want 3", b0.out__chan);
    else passed++;
    checks++;
    if (b0.out__first__RDY !== 1'b1) $display("FAIL st_rdy: got %b want 1", b0.out__first__RDY);
    else passed++;
    out_deq = 1'b1;
    tick();
    out_deq = 1'b0;
    #1;
    checks++;
    if ({b0.out__deq__RDY, b0.out__first} !== 17'h0)
      $display("FAIL st_drain: got %b/%h want 0/0", b0.out__deq__RDY, b0.out__first);
    else passed++;
  endtask

  // Continues from test_sticky_select: dut0 pointer sits at 3, FIFO empty.
  task automatic test_sticky_no_auto;
    set_elig(8'h20);
    set_data(5, 16'h5555);
    #1;
    checks++;
    if (b0.in__deq__ENA !== 8'h00) $display("FAIL sn_idle0: got %h want 00", b0.in__deq__ENA);
    else passed++;
    tick();
    #1;
    checks++;
    if ({b0.in__deq__ENA, b0.out__deq__RDY} !== 9'h0)
      $display("FAIL sn_idle1: got %h/%b want 00/0", b0.in__deq__ENA, b0.out__deq__RDY);
    else passed++;
    sel_ena = 1'b1;
    sel_v   = 32'd5;
    #1;
    checks++;
    if (b0.in__deq__ENA !== 8'h00) $display("FAIL sn_sel_cycle: got %h want 00", b0.in__deq__ENA);
    else passed++;
    tick();
    sel_ena = 1'b0;
    #1;
    checks++;
    if (b0.in__deq__ENA !== 8'h20) $display("FAIL sn_ena: got %h want 20", b0.in__deq__ENA);
    else passed++;
    tick();
    set_elig(8'h00);
    #1;
    checks++;
    if ({b0.out__chan, b0.out__first} !== {3'd5, 16'h5555})
      $display("FAIL sn_out: got %0d/%h want 5/5555", b0.out__chan, b0.out__first);
    else passed++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_elig(8'hff);
    for (int i = 0; i < 8; i++) set_data(i, 16'h1000 + 16'(i));
    out_deq = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (b1.in__deq__ENA !== 8'(1 << (k % 8)))
        $display("FAIL rr_grant%0d: got %h want %h", k, b1.in__deq__ENA, 8'(1 << (k % 8)));
      else passed++;
      if (k > 0) begin
        checks++;
        if ({b1.out__deq__RDY, b1.out__chan, b1.out__first} !==
            {1'b1, 3'((k - 1) % 8), 16'h1000 + 16'((k - 1) % 8)})
          $display("FAIL rr_out%0d: got %b/%0d/%h want 1/%0d/%h", k, b1.out__deq__RDY,
                   b1.out__chan, b1.out__first, (k - 1) % 8, 16'h1000 + 16'((k - 1) % 8));
        else passed++;
      end
      tick();
    end
    set_elig(8'h00);
    tick();
    tick();
    out_deq = 1'b0;
  endtask

  task automatic test_rr_sparse;
    do_reset();
    sel_ena = 1'b1;
    sel_v   = 32'd7;
    tick();
    sel_ena   = 1'b0;
    deq_rdy   = 8'h46;
    first_rdy = 8'h64;
    out_deq   = 1'b1;
    #1;
    checks++;
    if (b1.in__deq__ENA !== 8'h04) $display("FAIL sp_g2: got %h want 04", b1.in__deq__ENA);
    else passed++;
    tick();
    #1;
    checks++;
    if (b1.in__deq__ENA !== 8'h40) $display("FAIL sp_g6: got %h want 40", b1.in__deq__ENA);
    else passed++;
    tick();
    #1;
    checks++;
    if (b1.in__deq__ENA !== 8'h04) $display("FAIL sp_wrap: got %h want 04", b1.in__deq__ENA);
    else passed++;
    set_elig(8'h00);
    tick();
    tick();
    out_deq = 1'b0;
  endtask

  task automatic test_full_empty;
    do_reset();
    set_elig(8'h02);
    set_data(1, 16'h1111);
    #1;
    checks++;
    if (b1.in__deq__ENA !== 8'h02) $display("FAIL fe_p0: got %h want 02", b1.in__deq__ENA);
    else passed++;
    tick();
    set_data(1, 16'h2222);
    #1;
    checks++;
    if ({b1.in__deq__ENA, b1.out__first} !== {8'h02, 16'h1111})
      $display("FAIL fe_p1: got %h/%h want 02/1111", b1.in__deq__ENA, b1.out__first);
    else passed++;
    tick();
    #1;
    checks++;
    if (b1.in__deq__ENA !== 8'h00) $display("FAIL fe_full: got %h want 00", b1.in__deq__ENA);
    else passed++;
    out_deq = 1'b1;
    set_data(1, 16'h3333);
    #1;
    checks++;
    if (b1.in__deq__ENA !== 8'h00) $display("FAIL fe_full_pop: got %h want 00", b1.in__deq__ENA);
    else passed++;
    tick();
    out_deq = 1'b0;
    #1;
    checks++;
    if ({b1.in__deq__ENA, b1.out__first} !== {8'h02, 16'h2222})
      $display("FAIL fe_resume: got %h/%h want 02/2222", b1.in__deq__ENA, b1.out__first);
    else passed++;
    tick();
    #1;
    checks++;
    if ({b1.in__deq__ENA, b1.out__first} !== {8'h00, 16'h2222})
      $display("FAIL fe_full2: got %h/%h want 00/2222", b1.in__deq__ENA, b1.out__first);
    else passed++;
    set_elig(8'h00);
    out_deq = 1'b1;
    tick();
    #1;
    checks++;
    if (b1.out__first !== 16'h3333) $display("FAIL fe_tail: got %h want 3333", b1.out__first);
    else passed++;
    tick();
    #1;
    checks++;
    if (b1.out__deq__RDY !== 1'b0) $display("FAIL fe_empty: got %b want 0", b1.out__deq__RDY);
    else passed++;
    tick();
    out_deq = 1'b0;
    set_elig(8'h10);
    set_data(4, 16'h4444);
    #1;
    checks++;
    if ({b1.out__deq__RDY, b1.in__deq__ENA} !== {1'b0, 8'h10})
      $display("FAIL fe_empty_pop: got %b/%h want 0/10", b1.out__deq__RDY, b1.in__deq__ENA);
    else passed++;
    tick();
    set_elig(8'h00);
    #1;
    checks++;
    if ({b1.out__deq__RDY, b1.out__chan, b1.out__first} !== {1'b1, 3'd4, 16'h4444})
      $display("FAIL fe_after: got %b/%0d/%h want 1/4/4444", b1.out__deq__RDY, b1.out__chan,
               b1.out__first);
    else passed++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_elig(8'hff);
    for (int i = 0; i < 8; i++) set_data(i, 16'h2000 + 16'(i));
    tick();
    tick();
    #1;
    checks++;
    if (b1.out__first__RDY !== 1'b1) $display("FAIL rm_queued: got %b want 1", b1.out__first__RDY);
    else passed++;
    RST = 1'b1;
    #1;
    checks++;
    if ({b1.out__first__RDY, b1.in__deq__ENA, b1.out__first} !== 25'h0)
      $display("FAIL rm_async: got %b/%h/%h want 0/00/0000", b1.out__first__RDY,
               b1.in__deq__ENA, b1.out__first);
    else passed++;
    @(posedge CLK);
    #2;
    RST     = 1'b0;
    sel_ena = 1'b1;
    sel_v   = 32'd40;
    #1;
    checks++;
    if (b1.in__deq__ENA !== 8'h01) $display("FAIL rm_first: got %h want 01", b1.in__deq__ENA);
    else passed++;
    tick();
    sel_v = 32'd43;
    #1;
    checks++;
    if ({b1.in__deq__ENA, b0.in__deq__ENA, b1.out__chan} !== {8'h02, 8'h01, 3'd0})
      $display("FAIL rm_sel40: got %h/%h/%0d want 02/01/0", b1.in__deq__ENA, b0.in__deq__ENA,
               b1.out__chan);
    else passed++;
    tick();
    sel_ena = 1'b0;
    #1;
    checks++;
    if ({b1.in__deq__ENA, b0.in__deq__ENA} !== {8'h00, 8'h00})
      $display("FAIL rm_sel43: got %h/%h want 00/00", b1.in__deq__ENA, b0.in__deq__ENA);
    else passed++;
    out_deq = 1'b1;
    #1;
    checks++;
    if (b1.out__first !== 16'h2000) $display("FAIL rm_head: got %h want 2000", b1.out__first);
    else passed++;
    tick();
    out_deq = 1'b0;
    #1;
    checks++;
    if ({b1.in__deq__ENA, b0.in__deq__ENA} !== {8'h04, 8'h01})
      $display("FAIL rm_next: got %h/%h want 04/01", b1.in__deq__ENA, b0.in__deq__ENA);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sticky_select();
    test_sticky_no_auto();
    test_back_to_back();
    test_rr_sparse();
    test_full_empty();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
